display_scan_controller: RTL and testbench

DISPLAY_SCAN_CONTROLLER -- requirements
Module: display_scan_controller

---
 rtl/display_pkg.sv | 26 ++
 rtl/seg7_decoder.sv | 27 ++
 rtl/display_scan_controller.sv | 185 ++++++++++++++++++
 tb/tb_display_scan_controller.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared definitions for the multiplexed 7-segment scan controller:
// scan state encoding, segment patterns and the digit count.
package display_pkg;

    localparam int unsigned DIGITS = 4;

    typedef enum logic [1:0] {
        ST_GUARD = 2'd0,
        ST_ON    = 2'd1,
        ST_OFF   = 2'd2
    } scan_state_t;

    // Segment order is {g,f,e,d,c,b,a}, active-high.
    localparam logic [6:0] SEG_0    = 7'b0111111;
    localparam logic [6:0] SEG_1    = 7'b0000110;
    localparam logic [6:0] SEG_2    = 7'b1011011;
    localparam logic [6:0] SEG_3    = 7'b1001111;
    localparam logic [6:0] SEG_4    = 7'b1100110;
    localparam logic [6:0] SEG_5    = 7'b1101101;
    localparam logic [6:0] SEG_6    = 7'b1111101;
    localparam logic [6:0] SEG_7    = 7'b0000111;
    localparam logic [6:0] SEG_8    = 7'b1111111;
    localparam logic [6:0] SEG_9    = 7'b1101111;
    localparam logic [6:0] SEG_DASH = 7'b1000000;

endpackage

// File: rtl/seg7_decoder.sv
// BCD nibble to 7-segment pattern; non-decimal codes show a dash.
module seg7_decoder
    import display_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    // Pure lookup, no state.
    always_comb begin
        seg_o = SEG_DASH;
        case (nibble_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/display_scan_controller.sv
// Four-digit multiplexed 7-segment scan controller.
//
// state    | meaning
// ---------+--------------------------------------------------------
// ST_GUARD | slot start, all anodes off so the previous digit fades
// ST_ON    | current digit's anode driven, segments shown
// ST_OFF   | rest of the slot after the brightness on-time, dark
//
// A new value is taken into a pending register by a valid/ready
// handshake and only moves to the displayed register at frame start,
// so a frame never mixes two values. All outputs are registered and
// computed from next-cycle values so they move with the state.
module display_scan_controller #(
    parameter int unsigned DIGITS       = display_pkg::DIGITS,
    parameter int unsigned SLOT_CYCLES  = 100000,
    parameter int unsigned BLANK_CYCLES = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [15:0]       load_data,
    input  logic [3:0]        load_dp,
    input  logic              blank_lz,
    input  logic [3:0]        bright,
    output logic [6:0]        seg,
    output logic              dp,
    output logic [DIGITS-1:0] an,
    output logic              frame_start
);

    import display_pkg::*;

    localparam int unsigned      CNT_W    = $clog2(SLOT_CYCLES);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SLOT_CYCLES - 1);
    localparam logic [31:0]      SPAN     = 32'(SLOT_CYCLES - BLANK_CYCLES);
    localparam logic [31:0]      BLANK    = 32'(BLANK_CYCLES);

    scan_state_t        state_q, state_d;
    logic [CNT_W-1:0]   slot_cnt_q, slot_cnt_d;
    logic [1:0]         digit_q, digit_d;
    logic               run_q, run_d;
    logic [3:0]         bright_q, bright_d;
    logic               pending_q, pending_d;
    logic [15:0]        pend_data_q, pend_data_d;
    logic [3:0]         pend_dp_q, pend_dp_d;
    logic [15:0]        act_data_q, act_data_d;
    logic [3:0]         act_dp_q, act_dp_d;
    logic               load_ready_q, load_ready_d;
    logic               frame_start_q, frame_start_d;
    logic [6:0]         seg_q, seg_d;
    logic               dp_q, dp_d;
    logic [DIGITS-1:0]  an_q, an_d;

    logic [31:0]        cnt_ext;
    logic [31:0]        on_end;
    logic [3:0]         nibble_sel;
    logic [6:0]         seg_dec;
    logic               blank_digit;

    seg7_decoder u_dec (
        .nibble_i (nibble_sel),
        .seg_o    (seg_dec)
    );

    // Next-state: slot timing, handshake/commit, state and output decode.
    always_comb begin
        slot_cnt_d    = slot_cnt_q;
        digit_d       = digit_q;
        run_d         = run_q;
        bright_d      = bright_q;
        pending_d     = pending_q;
        pend_data_d   = pend_data_q;
        pend_dp_d     = pend_dp_q;
        act_data_d    = act_data_q;
        act_dp_d      = act_dp_q;
        state_d       = ST_GUARD;
        seg_d         = 7'd0;
        dp_d          = 1'b0;
        an_d          = '1;
        blank_digit   = 1'b0;

        // First running cycle after reset is the start of digit 0's slot.
        if (!run_q) begin
            run_d      = 1'b1;
            slot_cnt_d = '0;
            digit_d    = 2'd0;
        end else if (slot_cnt_q == LAST_CNT) begin
            slot_cnt_d = '0;
            digit_d    = digit_q + 2'd1;
        end else begin
            slot_cnt_d = slot_cnt_q + CNT_W'(1);
        end

        frame_start_d = (slot_cnt_d == '0) && (digit_d == 2'd0);

        // Commit uses the flag as it stood in the frame_start cycle, so a
        // value accepted in that same cycle waits for the next frame.
        if (frame_start_q && pending_q) begin
            act_data_d = pend_data_q;
            act_dp_d   = pend_dp_q;
            pending_d  = 1'b0;
        end
        if (load_valid && load_ready_q) begin
            pend_data_d = load_data;
            pend_dp_d   = load_dp;
            pending_d   = 1'b1;
        end
        load_ready_d = ~pending_d;

        if (slot_cnt_d == '0) begin
            bright_d = bright;
        end

        cnt_ext = 32'(slot_cnt_d);
        on_end  = BLANK + ((SPAN * {28'd0, bright_d}) >> 4);

        if (cnt_ext < BLANK) begin
            state_d = ST_GUARD;
        end else if (cnt_ext < on_end) begin
            state_d = ST_ON;
        end else begin
            state_d = ST_OFF;
        end

        nibble_sel = act_data_d[{digit_d, 2'b00} +: 4];

        case (digit_d)
            2'd3:    blank_digit = blank_lz && (act_data_d[15:12] == 4'd0);
            2'd2:    blank_digit = blank_lz && (act_data_d[15:8] == 8'd0);
            2'd1:    blank_digit = blank_lz && (act_data_d[15:4] == 12'd0);
            default: blank_digit = 1'b0;
        endcase

        if (state_d == ST_ON) begin
            an_d  = ~(DIGITS'(1) << digit_d);
            seg_d = blank_digit ? 7'd0 : seg_dec;
            dp_d  = act_dp_d[digit_d];
        end
    end

    // State and data registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= ST_GUARD;
            slot_cnt_q    <= '0;
            digit_q       <= 2'd0;
            run_q         <= 1'b0;
            bright_q      <= 4'd0;
            pending_q     <= 1'b0;
            pend_data_q   <= 16'd0;
            pend_dp_q     <= 4'd0;
            act_data_q    <= 16'd0;
            act_dp_q      <= 4'd0;
            load_ready_q  <= 1'b0;
            frame_start_q <= 1'b0;
            seg_q         <= 7'd0;
            dp_q          <= 1'b0;
            an_q          <= '1;
        end else begin
            state_q       <= state_d;
            slot_cnt_q    <= slot_cnt_d;
            digit_q       <= digit_d;
            run_q         <= run_d;
            bright_q      <= bright_d;
            pending_q     <= pending_d;
            pend_data_q   <= pend_data_d;
            pend_dp_q     <= pend_dp_d;
            act_data_q    <= act_data_d;
            act_dp_q      <= act_dp_d;
            load_ready_q  <= load_ready_d;
            frame_start_q <= frame_start_d;
            seg_q         <= seg_d;
            dp_q          <= dp_d;
            an_q          <= an_d;
        end
    end

    assign load_ready  = load_ready_q;
    assign frame_start = frame_start_q;
    assign seg         = seg_q;
    assign dp          = dp_q;
    assign an          = an_q;

endmodule

// File: tb/tb_display_scan_controller.sv
// Bench for display_scan_controller: a cycle-count based model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_display_scan_controller;

    localparam int SLOT  = 40;
    localparam int BLANK = 8;
    localparam int FRAME = 4 * SLOT;

    logic        clk = 1'b0;
    logic        reset;
    logic        load_valid;
    logic        load_ready;
    logic [15:0] load_data;
    logic [3:0]  load_dp;
    logic        blank_lz;
    logic [3:0]  bright;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        frame_start;

    int checks   = 0;
    int failures = 0;
    int k        = 0;

    display_scan_controller #(
        .DIGITS       (4),
        .SLOT_CYCLES  (SLOT),
        .BLANK_CYCLES (BLANK)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .load_valid  (load_valid),
        .load_ready  (load_ready),
        .load_data   (load_data),
        .load_dp     (load_dp),
        .blank_lz    (blank_lz),
        .bright      (bright),
        .seg         (seg),
        .dp          (dp),
        .an          (an),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] seg_of(input logic [3:0] n);
        case (n)
            4'd0:    return 7'h3F;
            4'd1:    return 7'h06;
            4'd2:    return 7'h5B;
            4'd3:    return 7'h4F;
            4'd4:    return 7'h66;
            4'd5:    return 7'h6D;
            4'd6:    return 7'h7D;
            4'd7:    return 7'h07;
            4'd8:    return 7'h7F;
            4'd9:    return 7'h6F;
            default: return 7'h40;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit          m_started = 1'b0;
    bit          m_run;
    int          m_t;
    int          m_bright;
    bit          m_pending;
    logic [15:0] m_pdata, m_active;
    logic [3:0]  m_pdp, m_adp;
    logic [3:0]  exp_an;
    logic [6:0]  exp_seg;
    logic        exp_dp, exp_ready, exp_fs;
    int          m_slot, m_digit, m_on_len;
    logic [15:0] m_hi;

    // Model advance: time since the first running cycle determines everything.
    always @(posedge clk) begin
        if (!reset) begin
            m_run     = 1'b0;
            m_t       = 0;
            m_bright  = 0;
            m_pending = 1'b0;
            m_pdata   = 16'd0;
            m_pdp     = 4'd0;
            m_active  = 16'd0;
            m_adp     = 4'd0;
            exp_an    = 4'hF;
            exp_seg   = 7'd0;
            exp_dp    = 1'b0;
            exp_ready = 1'b0;
            exp_fs    = 1'b0;
        end else begin
            if (exp_fs && m_pending) begin
                m_active  = m_pdata;
                m_adp     = m_pdp;
                m_pending = 1'b0;
            end
            if (load_valid && exp_ready) begin
                m_pdata   = load_data;
                m_pdp     = load_dp;
                m_pending = 1'b1;
            end
            if (!m_run) begin
                m_run = 1'b1;
                m_t   = 0;
            end else begin
                m_t++;
            end
            m_slot  = m_t % SLOT;
            m_digit = (m_t / SLOT) % 4;
            if (m_slot == 0) m_bright = int'(bright);
            m_on_len  = ((SLOT - BLANK) * m_bright) / 16;
            exp_ready = !m_pending;
            exp_fs    = (m_t % FRAME) == 0;
            exp_an    = 4'hF;
            exp_seg   = 7'd0;
            exp_dp    = 1'b0;
            if (m_slot >= BLANK && m_slot < BLANK + m_on_len) begin
                exp_an[m_digit] = 1'b0;
                m_hi = m_active >> (4 * m_digit);
                if (blank_lz && m_digit != 0 && m_hi == 16'd0) exp_seg = 7'd0;
                else exp_seg = seg_of(m_hi[3:0]);
                exp_dp = m_adp[m_digit];
            end
        end
        m_started = 1'b1;
    end

    // Compare every cycle on the falling edge.
    always @(negedge clk) begin
        if (m_started) begin
            chk("model_an", 32'(an), 32'(exp_an));
            chk("model_seg", 32'(seg), 32'(exp_seg));
            chk("model_dp", 32'(dp), 32'(exp_dp));
            chk("model_ready", 32'(load_ready), 32'(exp_ready));
            chk("model_fs", 32'(frame_start), 32'(exp_fs));
        end
    end

    // ---------------- directed stimulus ----------------
    logic [3:0] AN_SEQ [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    task automatic step();
        @(negedge clk);
        k++;
    endtask

    task automatic run_to(input int t);
        while (k < t) step();
    endtask

    task automatic wait_fs();
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (frame_start !== 1'b1 && n < 400);
        chk("fs_wait", 32'(frame_start), 32'd1);
        k = 0;
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] p);
        int n;
        n = 0;
        load_valid = 1'b1;
        load_data  = d;
        load_dp    = p;
        while (load_ready !== 1'b1 && n < 400) begin
            step();
            n++;
        end
        chk("load_accept", 32'(load_ready), 32'd1);
        step();
        load_valid = 1'b0;
    endtask

    task automatic measure(output int on_cnt, input bit chk_an);
        on_cnt = 0;
        for (int i = 0; i < FRAME; i++) begin
            if (an !== 4'hF) on_cnt++;
            if (chk_an && (k % SLOT) == BLANK) chk("scan_an", 32'(an), 32'(AN_SEQ[k / SLOT]));
            step();
        end
        chk("fs_period", 32'(frame_start), 32'd1);
        k = 0;
    endtask

    initial begin
        int  cnt;
        bit  prev_fs;
        int  n;
        reset      = 1'b0;
        load_valid = 1'b0;
        load_data  = 16'd0;
        load_dp    = 4'd0;
        blank_lz   = 1'b0;
        bright     = 4'd0;
        repeat (3) @(negedge clk);
        chk("rst_an", 32'(an), 32'hF);
        chk("rst_seg", 32'(seg), 32'd0);
        chk("rst_ready", 32'(load_ready), 32'd0);
        chk("rst_fs", 32'(frame_start), 32'd0);

        // Release: first running cycle is a frame start with ready high.
        bright = 4'd15;
        reset  = 1'b1;
        step();
        chk("rel_fs", 32'(frame_start), 32'd1);
        chk("rel_ready", 32'(load_ready), 32'd1);
        k = 0;

        // Scan 0x1234 at full brightness.
        do_load(16'h1234, 4'b0000);
        chk("pend_ready_low", 32'(load_ready), 32'd0);
        wait_fs();
        run_to(8);
        chk("scan_d0_seg", 32'(seg), 32'h66);
        run_to(48);
        chk("scan_d1_seg", 32'(seg), 32'h4F);
        run_to(88);
        chk("scan_d2_seg", 32'(seg), 32'h5B);
        run_to(128);
        chk("scan_d3_seg", 32'(seg), 32'h06);
        wait_fs();
        measure(cnt, 1'b1);
        chk("on_cnt_b15", 32'(cnt), 32'd120);

        // Brightness 8 then 0.
        bright = 4'd8;
        wait_fs();
        run_to(7);
        chk("b8_guard", 32'(an), 32'hF);
        run_to(8);
        chk("b8_on_first", 32'(an), 32'hE);
        run_to(23);
        chk("b8_on_last", 32'(an), 32'hE);
        run_to(24);
        chk("b8_off", 32'(an), 32'hF);
        wait_fs();
        measure(cnt, 1'b0);
        chk("on_cnt_b8", 32'(cnt), 32'd64);
        bright = 4'd0;
        wait_fs();
        measure(cnt, 1'b0);
        chk("on_cnt_b0", 32'(cnt), 32'd0);

        // Handshake: second value held until after the next frame start.
        bright = 4'd15;
        wait_fs();
        run_to(50);
        do_load(16'h5678, 4'b0101);
        load_valid = 1'b1;
        load_data  = 16'h9999;
        load_dp    = 4'b0000;
        chk("hs_busy", 32'(load_ready), 32'd0);
        prev_fs = 1'b0;
        n = 0;
        while (load_ready !== 1'b1 && n < 400) begin
            prev_fs = frame_start;
            step();
            n++;
            if (prev_fs) k = 1;
        end
        chk("hs_ready_after_fs", 32'(prev_fs), 32'd1);
        chk("hs_ready_k", 32'(k), 32'd1);
        step();
        load_valid = 1'b0;
        chk("hs_second_pending", 32'(load_ready), 32'd0);
        run_to(8);
        chk("hs_d0_seg", 32'(seg), 32'h7F);
        chk("hs_d0_dp", 32'(dp), 32'd1);
        run_to(48);
        chk("hs_d1_seg", 32'(seg), 32'h07);
        chk("hs_d1_dp", 32'(dp), 32'd0);
        run_to(88);
        chk("hs_d2_seg", 32'(seg), 32'h7D);
        run_to(128);
        chk("hs_d3_seg", 32'(seg), 32'h6D);
        wait_fs();
        run_to(8);
        chk("hs_next_seg", 32'(seg), 32'h6F);

        // Leading-zero blanking.
        blank_lz = 1'b1;
        do_load(16'h0070, 4'b0000);
        wait_fs();
        run_to(8);
        chk("lz_d0", 32'(seg), 32'h3F);
        run_to(48);
        chk("lz_d1", 32'(seg), 32'h07);
        chk("lz_d1_an", 32'(an), 32'hD);
        run_to(88);
        chk("lz_d2", 32'(seg), 32'd0);
        chk("lz_d2_an", 32'(an), 32'hB);
        run_to(128);
        chk("lz_d3", 32'(seg), 32'd0);
        do_load(16'h0000, 4'b0000);
        wait_fs();
        run_to(8);
        chk("lz0_d0", 32'(seg), 32'h3F);
        run_to(48);
        chk("lz0_d1", 32'(seg), 32'd0);

        // Invalid nibble, then reset mid-ON with a pending value.
        blank_lz = 1'b0;
        do_load(16'h00A0, 4'b0000);
        wait_fs();
        run_to(48);
        chk("dash_d1", 32'(seg), 32'h40);
        run_to(88);
        chk("inv_d2_zero", 32'(seg), 32'h3F);
        do_load(16'h8888, 4'b0000);
        run_to(95);
        reset = 1'b0;
        step();
        chk("mid_rst_an", 32'(an), 32'hF);
        chk("mid_rst_seg", 32'(seg), 32'd0);
        chk("mid_rst_ready", 32'(load_ready), 32'd0);
        reset = 1'b1;
        step();
        chk("rerel_fs", 32'(frame_start), 32'd1);
        chk("rerel_ready", 32'(load_ready), 32'd1);
        k = 0;
        run_to(8);
        chk("rerel_d0", 32'(seg), 32'h3F);
        run_to(48);
        chk("rerel_d1", 32'(seg), 32'h3F);
        wait_fs();
        run_to(48);
        chk("discard_d1", 32'(seg), 32'h3F);
        chk("discard_ready", 32'(load_ready), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule
